// File: rtl/data_mem_access_unit_pkg.sv
// Shared definitions for the MEM-stage data access unit: MEM_RW codes, FSM states, decode helpers.
package data_mem_access_unit_pkg;

    localparam logic [2:0] MEMRW_LB  = 3'b000;
    localparam logic [2:0] MEMRW_LH  = 3'b001;
    localparam logic [2:0] MEMRW_LW  = 3'b010;
    localparam logic [2:0] MEMRW_SB  = 3'b011;
    localparam logic [2:0] MEMRW_LBU = 3'b100;
    localparam logic [2:0] MEMRW_LHU = 3'b101;
    localparam logic [2:0] MEMRW_SH  = 3'b110;
    localparam logic [2:0] MEMRW_SW  = 3'b111;

    localparam int MEMRW_EN = 3;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_WRITE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    function automatic logic is_load(input logic [2:0] op);
        return !(op == MEMRW_SB || op == MEMRW_SH || op == MEMRW_SW);
    endfunction

    // Byte accesses can never be misaligned; halves need bit 0 clear, words need both.
    function automatic logic is_misaligned(input logic [2:0] op, input logic [1:0] off);
        logic half, word;
        half = (op == MEMRW_LH) || (op == MEMRW_LHU) || (op == MEMRW_SH);
        word = (op == MEMRW_LW) || (op == MEMRW_SW);
        return (half && off[0]) || (word && (off != 2'b00));
    endfunction

endpackage

// File: rtl/data_mem_access_unit_aligner.sv
// Combinational lane logic: extract/extend a load lane, merge a store lane into a read word.
module load_store_aligner
    import data_mem_access_unit_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [1:0]  offset,
    input  logic [31:0] rdata,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] store_data
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    always_comb begin
        lane_b     = rdata[{offset, 3'b000} +: 8];
        lane_h     = offset[1] ? rdata[31:16] : rdata[15:0];
        load_data  = rdata;
        store_data = rdata;
        case (op)
            MEMRW_LB:  load_data = {{24{lane_b[7]}}, lane_b};
            MEMRW_LBU: load_data = {24'd0, lane_b};
            MEMRW_LH:  load_data = {{16{lane_h[15]}}, lane_h};
            MEMRW_LHU: load_data = {16'd0, lane_h};
            default:   load_data = rdata;
        endcase
        if (op == MEMRW_SB)
            store_data[{offset, 3'b000} +: 8] = wdata[7:0];
        else if (op == MEMRW_SH)
            store_data[{offset[1], 4'b0000} +: 16] = wdata[15:0];
    end

endmodule

// File: rtl/data_mem_access_unit.sv
// MEM-stage responder: runs loads/stores against a word-wide memory, with read-modify-write
// for sub-word stores, and stalls the pipeline until each access finishes.
module data_mem_access_unit
    import data_mem_access_unit_pkg::*;
#(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
) (
    input  logic              CLK,
    input  logic              RESET,
    input  logic [3:0]        MEM_RW,
    input  logic [ADDR_W-1:0] ADDRESS,
    input  logic [31:0]       WRITE_DATA,
    output logic [31:0]       READ_DATA,
    output logic              BUSYWAIT,
    output logic              MISALIGNED,
    output logic              MEM_READ,
    output logic              MEM_WRITE,
    output logic [ADDR_W-3:0] MEM_ADDRESS,
    output logic [31:0]       MEM_WRITEDATA,
    input  logic [31:0]       MEM_READDATA,
    input  logic              MEM_BUSYWAIT
);

    if (DATA_W != 32) begin : g_bad_width
        $error("data_mem_access_unit supports DATA_W == 32 only");
    end

    state_t      state;
    logic [2:0]  op_q;
    logic [1:0]  off_q;
    logic [31:0] wdata_q;
    logic [31:0] load_data;
    logic [31:0] store_data;
    logic        access;

    assign access   = MEM_RW[MEMRW_EN];
    assign BUSYWAIT = (state == ST_READ) || (state == ST_WRITE) || (state == ST_IDLE && access);

    load_store_aligner u_aligner (
        .op         (op_q),
        .offset     (off_q),
        .rdata      (MEM_READDATA),
        .wdata      (wdata_q),
        .load_data  (load_data),
        .store_data (store_data)
    );

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state         <= ST_IDLE;
            op_q          <= 3'd0;
            off_q         <= 2'd0;
            wdata_q       <= 32'd0;
            READ_DATA     <= 32'd0;
            MISALIGNED    <= 1'b0;
            MEM_READ      <= 1'b0;
            MEM_WRITE     <= 1'b0;
            MEM_ADDRESS   <= '0;
            MEM_WRITEDATA <= 32'd0;
        end else begin
            case (state)
                ST_IDLE: if (access) begin
                    op_q        <= MEM_RW[2:0];
                    off_q       <= ADDRESS[1:0];
                    wdata_q     <= WRITE_DATA;
                    MEM_ADDRESS <= ADDRESS[ADDR_W-1:2];
                    if (is_misaligned(MEM_RW[2:0], ADDRESS[1:0])) begin
                        MISALIGNED <= 1'b1;
                        READ_DATA  <= 32'd0;
                        state      <= ST_DONE;
                    end else if (MEM_RW[2:0] == MEMRW_SW) begin
                        MEM_WRITE     <= 1'b1;
                        MEM_WRITEDATA <= WRITE_DATA;
                        state         <= ST_WRITE;
                    end else begin
                        MEM_READ <= 1'b1;
                        state    <= ST_READ;
                    end
                end
                // Sub-word stores hand over from read to write on the same edge, so the
                // two requests never overlap.
                ST_READ: if (!MEM_BUSYWAIT) begin
                    MEM_READ <= 1'b0;
                    if (is_load(op_q)) begin
                        READ_DATA <= load_data;
                        state     <= ST_DONE;
                    end else begin
                        MEM_WRITEDATA <= store_data;
                        MEM_WRITE     <= 1'b1;
                        state         <= ST_WRITE;
                    end
                end
                ST_WRITE: if (!MEM_BUSYWAIT) begin
                    MEM_WRITE <= 1'b0;
                    state     <= ST_DONE;
                end
                default: begin
                    MISALIGNED <= 1'b0;
                    state      <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_data_mem_access_unit.sv
// Scoreboard bench for data_mem_access_unit with a latency-programmable word memory model.
module tb_data_mem_access_unit;

    logic        CLK = 1'b0;
    logic        RESET;
    logic [3:0]  MEM_RW;
    logic [31:0] ADDRESS;
    logic [31:0] WRITE_DATA;
    logic [31:0] READ_DATA;
    logic        BUSYWAIT;
    logic        MISALIGNED;
    logic        MEM_READ;
    logic        MEM_WRITE;
    logic [29:0] MEM_ADDRESS;
    logic [31:0] MEM_WRITEDATA;
    logic [31:0] MEM_READDATA;
    logic        MEM_BUSYWAIT;

    always #5 CLK = ~CLK;

    data_mem_access_unit #(.ADDR_W(32), .DATA_W(32)) dut (
        .CLK(CLK), .RESET(RESET), .MEM_RW(MEM_RW), .ADDRESS(ADDRESS), .WRITE_DATA(WRITE_DATA),
        .READ_DATA(READ_DATA), .BUSYWAIT(BUSYWAIT), .MISALIGNED(MISALIGNED),
        .MEM_READ(MEM_READ), .MEM_WRITE(MEM_WRITE), .MEM_ADDRESS(MEM_ADDRESS),
        .MEM_WRITEDATA(MEM_WRITEDATA), .MEM_READDATA(MEM_READDATA), .MEM_BUSYWAIT(MEM_BUSYWAIT)
    );

    // Memory model: each request is held busy for n_busy cycles, then completes.
    logic [31:0] mem [16];
    int n_busy = 0;
    int busy_cnt = 0;
    int rd_cnt = 0;
    int wr_cnt = 0;
    logic overlap = 1'b0;

    assign MEM_READDATA = mem[MEM_ADDRESS[3:0]];
    assign MEM_BUSYWAIT = (MEM_READ || MEM_WRITE) && (busy_cnt < n_busy);

    always @(posedge CLK) begin
        if (MEM_READ || MEM_WRITE) begin
            if (busy_cnt >= n_busy) begin
                busy_cnt <= 0;
                if (MEM_WRITE) begin
                    mem[MEM_ADDRESS[3:0]] <= MEM_WRITEDATA;
                    wr_cnt <= wr_cnt + 1;
                end else begin
                    rd_cnt <= rd_cnt + 1;
                end
            end else begin
                busy_cnt <= busy_cnt + 1;
            end
        end else begin
            busy_cnt <= 0;
        end
    end

    always @(negedge CLK) if (MEM_READ && MEM_WRITE) overlap <= 1'b1;

    typedef struct {
        logic [31:0] rd;
        logic        mis;
        int          busy;
        int          nrd;
        int          nwr;
    } exp_t;

    exp_t        sb_q[$];
    logic [31:0] ref_mem [16];
    logic [31:0] last_rd = 32'd0;
    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%h exp=%h", tag, got, exp);
    endtask

    function automatic logic [31:0] ref_load(input logic [2:0] op, input logic [1:0] a,
                                             input logic [31:0] w);
        logic [7:0]  b;
        logic [15:0] h;
        case (a)
            2'd0:    b = w[7:0];
            2'd1:    b = w[15:8];
            2'd2:    b = w[23:16];
            default: b = w[31:24];
        endcase
        h = a[1] ? w[31:16] : w[15:0];
        case (op)
            3'b000:  return {{24{b[7]}}, b};
            3'b100:  return {24'd0, b};
            3'b001:  return {{16{h[15]}}, h};
            3'b101:  return {16'd0, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [31:0] ref_store(input logic [2:0] op, input logic [1:0] a,
                                              input logic [31:0] w, input logic [31:0] d);
        logic [31:0] r;
        r = w;
        if (op == 3'b111) r = d;
        else if (op == 3'b110) begin
            if (a[1]) r[31:16] = d[15:0];
            else      r[15:0]  = d[15:0];
        end else begin
            case (a)
                2'd0:    r[7:0]   = d[7:0];
                2'd1:    r[15:8]  = d[7:0];
                2'd2:    r[23:16] = d[7:0];
                default: r[31:24] = d[7:0];
            endcase
        end
        return r;
    endfunction

    function automatic logic ref_mis(input logic [2:0] op, input logic [1:0] a);
        return ((op == 3'b001 || op == 3'b101 || op == 3'b110) && a[0]) ||
               ((op == 3'b010 || op == 3'b111) && a != 2'd0);
    endfunction

    // Called at posedge+1 with the unit idle; returns once the DONE edge has passed.
    task automatic run_op(input logic [2:0] op, input logic [31:0] addr, input logic [31:0] wd,
                          input int n, output logic [31:0] rd_obs);
        exp_t e, g;
        int   cyc, r0, w0;
        logic ld;
        ld = !(op == 3'b011 || op == 3'b110 || op == 3'b111);
        e.mis = ref_mis(op, addr[1:0]);
        if (e.mis) begin
            e.rd = 32'd0; e.busy = 1; e.nrd = 0; e.nwr = 0;
        end else if (ld) begin
            e.rd = ref_load(op, addr[1:0], ref_mem[addr[5:2]]);
            e.busy = n + 2; e.nrd = 1; e.nwr = 0;
        end else begin
            e.rd = last_rd; e.nwr = 1;
            e.busy = (op == 3'b111) ? n + 2 : 2 * n + 3;
            e.nrd  = (op == 3'b111) ? 0 : 1;
            ref_mem[addr[5:2]] = ref_store(op, addr[1:0], ref_mem[addr[5:2]], wd);
        end
        last_rd = e.rd;
        chk("idle_mis_low", {31'd0, MISALIGNED}, 32'd0);
        n_busy = n;
        r0 = rd_cnt; w0 = wr_cnt;
        MEM_RW = {1'b1, op}; ADDRESS = addr; WRITE_DATA = wd;
        sb_q.push_back(e);
        cyc = 0;
        @(negedge CLK);
        while (BUSYWAIT === 1'b1 && cyc < 100) begin
            cyc++;
            @(negedge CLK);
        end
        g = sb_q.pop_front();
        rd_obs = READ_DATA;
        chk($sformatf("busy_cycles op%0d a%0h", op, addr), cyc, g.busy);
        chk($sformatf("read_data op%0d a%0h", op, addr), READ_DATA, g.rd);
        chk($sformatf("misaligned op%0d a%0h", op, addr), {31'd0, MISALIGNED}, {31'd0, g.mis});
        chk($sformatf("mem_reads op%0d a%0h", op, addr), rd_cnt - r0, g.nrd);
        chk($sformatf("mem_writes op%0d a%0h", op, addr), wr_cnt - w0, g.nwr);
        @(posedge CLK); #1;
        MEM_RW = 4'd0;
    endtask

    logic [31:0] rd;
    logic [2:0]  rop;
    logic [31:0] raddr;

    initial begin
        for (int i = 0; i < 16; i++) begin
            mem[i] = 32'd0;
            ref_mem[i] = 32'd0;
        end
        RESET = 1'b1; MEM_RW = 4'd0; ADDRESS = 32'd0; WRITE_DATA = 32'd0;
        repeat (2) @(negedge CLK);
        chk("rst_read_data", READ_DATA, 32'd0);
        chk("rst_mem_ctrl", {28'd0, MISALIGNED, MEM_READ, MEM_WRITE, BUSYWAIT}, 32'd0);
        chk("rst_mem_wdata", MEM_WRITEDATA, 32'd0);
        chk("rst_mem_addr", {2'b00, MEM_ADDRESS}, 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b0;

        run_op(3'b111, 32'h10, 32'h1122_3344, 2, rd);
        chk("sw_word", mem[4], 32'h1122_3344);
        run_op(3'b000, 32'h13, 32'd0, 1, rd);
        chk("lb_13", rd, 32'h0000_0011);
        run_op(3'b011, 32'h11, 32'hFFFF_FFB3, 1, rd);
        chk("sb_11_word", mem[4], 32'h1122_B344);
        run_op(3'b000, 32'h11, 32'd0, 0, rd);
        chk("lb_11", rd, 32'hFFFF_FFB3);
        run_op(3'b100, 32'h11, 32'd0, 3, rd);
        chk("lbu_11", rd, 32'h0000_00B3);
        run_op(3'b011, 32'h11, 32'h33, 0, rd);
        run_op(3'b011, 32'h12, 32'h0000_00AA, 2, rd);
        chk("sb_12_word", mem[4], 32'h11AA_3344);
        run_op(3'b101, 32'h12, 32'd0, 1, rd);
        chk("lhu_12", rd, 32'h0000_11AA);
        run_op(3'b010, 32'h12, 32'd0, 2, rd);
        chk("lw_mis_rd", rd, 32'd0);
        run_op(3'b110, 32'h11, 32'h5555, 0, rd);
        run_op(3'b111, 32'h12, 32'h6666_6666, 0, rd);
        run_op(3'b101, 32'h13, 32'd0, 0, rd);
        chk("mis_no_write", mem[4], 32'h11AA_3344);
        run_op(3'b110, 32'h12, 32'h0000_8001, 1, rd);
        run_op(3'b001, 32'h12, 32'd0, 1, rd);
        chk("lh_12", rd, 32'hFFFF_8001);
        run_op(3'b010, 32'h10, 32'd0, 0, rd);
        chk("lw_b2b_0", rd, 32'h8001_3344);
        run_op(3'b010, 32'h14, 32'd0, 0, rd);
        chk("lw_b2b_1", rd, 32'h0000_0000);

        // Reset in the middle of a stalled read.
        n_busy = 5;
        MEM_RW = {1'b1, 3'b010}; ADDRESS = 32'h10;
        @(posedge CLK); #1;
        chk("rst_pre_mem_read", {31'd0, MEM_READ}, 32'd1);
        @(posedge CLK); #1;
        RESET = 1'b1;
        #1;
        chk("rst_mid_mem_read", {31'd0, MEM_READ}, 32'd0);
        chk("rst_mid_busy_follows_rw", {31'd0, BUSYWAIT}, 32'd1);
        MEM_RW = 4'd0;
        #1;
        chk("rst_mid_busy_idle", {31'd0, BUSYWAIT}, 32'd0);
        @(posedge CLK); #1;
        RESET = 1'b0;
        last_rd = 32'd0;
        run_op(3'b010, 32'h10, 32'd0, 1, rd);
        chk("lw_after_rst", rd, 32'h8001_3344);

        for (int k = 0; k < 40; k++) begin
            rop   = 3'($urandom_range(0, 7));
            raddr = 32'($urandom_range(0, 63));
            if ($urandom_range(0, 3) != 0) begin
                if (rop == 3'b010 || rop == 3'b111) raddr[1:0] = 2'b00;
                else if (rop == 3'b001 || rop == 3'b101 || rop == 3'b110) raddr[0] = 1'b0;
            end
            run_op(rop, raddr, $urandom, $urandom_range(0, 3), rd);
        end

        for (int i = 0; i < 16; i++) chk($sformatf("final_mem[%0d]", i), mem[i], ref_mem[i]);
        chk("no_rd_wr_overlap", {31'd0, overlap}, 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
